// File: rtl/ysyx_23060187_seq_alu_if.sv
// Request/response bundle between EXU and the multi-cycle ALU.
// The master drives requests and consumes results; the slave is the ALU.
interface ysyx_23060187_seq_alu_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] opnum1;
   logic [WIDTH-1:0] opnum2;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             cout;
   logic             ovf;
   logic             illegal;

   modport master (
      output in_valid, op, opnum1, opnum2, flush, out_ready,
      input  in_ready, out_valid, result, zero, cout, ovf, illegal
   );

   modport slave (
      input  in_valid, op, opnum1, opnum2, flush, out_ready,
      output in_ready, out_valid, result, zero, cout, ovf, illegal
   );
endinterface

// File: rtl/ysyx_23060187_seq_alu.sv
// Multi-cycle integer ALU: single-cycle logic/arith/shift/compare ops plus
// iterative shift-add multiply and restoring unsigned divide, with handshakes.
module ysyx_23060187_seq_alu #(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input logic                    clk,
   input logic                    rst_n,
   ysyx_23060187_seq_alu_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   typedef enum logic [3:0] {
      OP_AND  = 4'd0,  OP_OR   = 4'd1,  OP_ADD = 4'd2,  OP_SLL  = 4'd3,
      OP_SRL  = 4'd4,  OP_XOR  = 4'd5,  OP_SUB = 4'd6,  OP_SRA  = 4'd7,
      OP_SLT  = 4'd8,  OP_SLTU = 4'd9,  OP_MUL = 4'd10, OP_MULHU = 4'd11,
      OP_DIVU = 4'd12, OP_REMU = 4'd13
   } op_t;

   state_t             state, state_n;
   logic               accept, in_ready, out_valid, last_iter, iter_op;
   logic [3:0]         op_q;
   logic [SHW-1:0]     count;
   logic [2*WIDTH-1:0] acc, acc_n;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH-1:0]   result, zero_r;
   logic               zero, cout, ovf, illegal;

   logic [WIDTH-1:0]   a, b, alu_r, iter_r;
   logic [SHW-1:0]     shamt;
   logic [WIDTH:0]     add_s, sub_s, mul_sum, div_sh, div_d;
   logic               alu_c, alu_v, alu_ill;

   assign a       = bus.opnum1;
   assign b       = bus.opnum2;
   assign shamt   = b[SHW-1:0];
   assign add_s   = {1'b0, a} + {1'b0, b};
   assign sub_s   = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
   assign iter_op = bus.op inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};

   always_comb begin
      // NOTE: every output gets a default first, so no path can infer a latch.
      alu_r   = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_ill = 1'b0;
      case (bus.op)
         OP_AND:  alu_r = a & b;
         OP_OR:   alu_r = a | b;
         OP_XOR:  alu_r = a ^ b;
         OP_ADD: begin
            alu_r = add_s[WIDTH-1:0];
            alu_c = add_s[WIDTH];
            alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_r = sub_s[WIDTH-1:0];
            alu_c = sub_s[WIDTH];
            alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLL:  alu_r = a << shamt;
         OP_SRL:  alu_r = a >> shamt;
         OP_SRA:  alu_r = $unsigned($signed(a) >>> shamt);
         OP_SLT:  alu_r = WIDTH'($signed(a) < $signed(b));
         OP_SLTU: alu_r = WIDTH'(a < b);
         OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: ;
         default: alu_ill = 1'b1;
      endcase
   end

   // acc holds {high/remainder, low/quotient}; opnd is the multiplicand or divisor.
   assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
   assign div_sh  = acc[2*WIDTH-1:WIDTH-1];
   assign div_d   = div_sh - {1'b0, opnd};

   always_comb begin
      acc_n = '0;
      if (op_q == OP_MUL || op_q == OP_MULHU)
         acc_n = {mul_sum, acc[WIDTH-1:1]};
      else
         acc_n = {div_d[WIDTH] ? div_sh[WIDTH-1:0] : div_d[WIDTH-1:0],
                  acc[WIDTH-2:0], ~div_d[WIDTH]};
   end

   // op bit 0 selects the upper half for both MULHU and REMU.
   assign iter_r    = op_q[0] ? acc_n[2*WIDTH-1:WIDTH] : acc_n[WIDTH-1:0];
   assign last_iter = (count == '0);

   always_comb begin
      state_n   = state;
      accept    = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid && !bus.flush) begin
               accept  = 1'b1;
               state_n = iter_op ? BUSY : DONE;
            end
         end
         BUSY: if (last_iter) state_n = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (bus.flush) state_n = IDLE;
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q    <= '0;
         count   <= '0;
         acc     <= '0;
         opnd    <= '0;
         result  <= '0;
         zero    <= 1'b0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
         illegal <= 1'b0;
      end else if (accept) begin
         op_q <= bus.op;
         if (iter_op) begin
            count <= SHW'(WIDTH - 1);
            if (bus.op == OP_MUL || bus.op == OP_MULHU) begin
               acc  <= {{WIDTH{1'b0}}, b};
               opnd <= a;
            end else begin
               acc  <= {{WIDTH{1'b0}}, a};
               opnd <= b;
            end
         end else begin
            result  <= alu_r;
            zero    <= (alu_r == '0);
            cout    <= alu_c;
            ovf     <= alu_v;
            illegal <= alu_ill;
         end
      end else if (state == BUSY && !bus.flush) begin
         acc   <= acc_n;
         count <= last_iter ? '0 : count - SHW'(1);
         if (last_iter) begin
            result  <= iter_r;
            zero    <= (iter_r == '0);
            cout    <= 1'b0;
            ovf     <= 1'b0;
            illegal <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.result    = result;
   assign bus.zero      = zero;
   assign bus.cout      = cout;
   assign bus.ovf       = ovf;
   assign bus.illegal   = illegal;
endmodule

// File: doc/ysyx_23060187_seq_alu.md
Name: ysyx_23060187_seq_alu

Overview:
Parametrised, multi-cycle integer ALU for the NPC execute stage. It extends the single-cycle ALU op set with signed shift and compare. It adds iterative multiply and unsigned divide/remainder. It has valid/ready handshakes on input and output so EXU can stall on long ops. Results and flags are registered and held until consumed.

Parameters:
WIDTH, 32, operand/result width in bits; power of two, 8 to 64.
SHW, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  operation request
in_ready  output  1  ALU can accept a request
op  input  4  operation code (see Behaviour)
opnum1  input  WIDTH  operand A
opnum2  input  WIDTH  operand B
flush  input  1  abort current operation
out_valid  output  1  result available
out_ready  input  1  consumer takes result
result  output  WIDTH  registered result
zero  output  1  result == 0
cout  output  1  carry-out (ADD) / no-borrow (SUB), else 0
ovf  output  1  signed overflow (ADD/SUB), else 0
illegal  output  1  op was 14 or 15

Behaviour:
- Op encoding:
  - 0 AND, 1 OR, 2 ADD, 3 SLL, 4 SRL, 5 XOR, 6 SUB, 7 SRA, 8 SLT (signed, result 1/0), 9 SLTU.
  - 10 MUL (low WIDTH of product), 11 MULHU (high WIDTH, unsigned), 12 DIVU, 13 REMU.
  - 14/15 illegal.
- Shifts use opnum2[SHW-1:0] only; upper bits are ignored.
- SUB is computed as A + ~B + 1 in WIDTH+1 bits; cout = bit WIDTH (1 = no borrow).
- ovf: ADD = A,B same sign and result sign differs; SUB = A,B signs differ and result sign differs from A.
- Divide by zero: DIVU result = all ones; REMU result = opnum1. This takes the normal iterative latency; no flag is raised.
- Illegal op: result 0, illegal=1, zero=1, single-cycle latency.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid, latch op/operands.
    - Ops 0-9 and 14-15: compute and register the result, go to DONE.
    - Ops 10-13: load the iteration counter with WIDTH-1, go to BUSY.
  - BUSY: in_ready=0. One iteration per cycle.
    - MUL/MULHU: shift-add, 2*WIDTH accumulator.
    - DIVU/REMU: restoring division, one quotient bit per cycle.
    - On counter==0, register the result and go to DONE.
  - DONE: out_valid=1; result and flags are stable. On out_ready, go to IDLE. No new request is accepted in DONE.
- Latency, from the accept edge N:
  - Single-cycle ops: out_valid=1 in cycle N+1.
  - Iterative ops: out_valid=1 in cycle N+WIDTH+1.
- Operands are sampled only at accept; input changes afterwards have no effect.
- out_valid stays high with outputs unchanged until out_ready=1. Back-to-back throughput for single-cycle ops is one per 2 cycles.
- flush: in any state it forces IDLE on the next edge and clears out_valid. The in-flight result is discarded.
  - flush has priority over in_valid and out_ready in the same cycle.
  - A request presented with flush is not accepted.
- Reset (rst_n=0 at edge): state=IDLE, out_valid=0, result=0, zero=0, cout=0, ovf=0, illegal=0, counter=0.
  - in_ready=1 after reset.
  - Reset mid-BUSY abandons the operation.
- zero, cout, ovf and illegal are registered together with result. All are 0 when the op does not define them.

Test Plan:
- Reset mid-BUSY (DIVU, 10 cycles in), rst_n=0 one cycle -> out_valid=0, in_ready=1, result=0; next ADD 1+1 -> result 2.
- ADD 0xFFFFFFFF+1 -> one cycle later out_valid=1, result 0, zero=1, cout=1, ovf=0; ADD 0x7FFFFFFF+1 -> 0x80000000, ovf=1, cout=0.
- SUB 5-7 -> 0xFFFFFFFE, cout=0, ovf=0; SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0; SRA 0x80000000 by 0x21 (uses 1) -> 0xC0000000; SLL 1 by 36 -> 0x10.
- MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001; MULHU same -> 0xFFFFFFFE; out_valid asserts exactly 33 cycles after accept; in_ready=0 throughout.
- DIVU 100/7 -> 14, REMU -> 2; DIVU x/0 -> 0xFFFFFFFF, REMU 0x1234/0 -> 0x1234; hold out_ready=0 5 cycles -> result stable, no new accept.
- flush during BUSY at cycle 10 -> out_valid never asserts, IDLE next cycle; op 15 -> result 0, illegal=1, zero=1.
